id_hazard_forward_unit: RTL and testbench



---
 rtl/id_hazard_forward_unit.sv | 124 ++++++++++++
 tb/tb_id_hazard_forward_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_forward_unit.sv
// ID-stage hazard detection and bypass selection: stalls the front end on
// producers whose result is not yet available and forwards MEM/WB results.
module id_hazard_forward_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_uses_rs,
    input  logic        i_id_uses_rt,
    input  logic        i_id_take_branch,
    input  logic        i_ex_reg_write,
    input  logic        i_ex_mem_read,
    input  logic [4:0]  i_ex_write_register,
    input  logic        i_mem_reg_write,
    input  logic        i_mem_mem_read,
    input  logic [4:0]  i_mem_write_register,
    input  logic [31:0] i_mem_alu_result,
    input  logic        i_wb_reg_write,
    input  logic [4:0]  i_wb_write_register,
    input  logic [31:0] i_wb_write_data,
    output logic [31:0] o_forwarded_value_a,
    output logic [31:0] o_forwarded_value_b,
    output logic        o_use_forwarded_a,
    output logic        o_use_forwarded_b,
    output logic        o_stall,
    output logic        o_bubble,
    output logic        o_flush_if,
    output logic [15:0] o_stall_count,
    output logic [15:0] o_flush_count
);

    typedef enum logic {RUN, STALL_LAST} state_t;

    state_t      state;
    logic        live_rs, live_rt;
    logic        ex_ok, mem_ok, wb_ok;
    logic        ex_hit_a, mem_hit_a, wb_hit_a;
    logic        ex_hit_b, mem_hit_b, wb_hit_b;
    logic [1:0]  len_a, len_b, need_len;

    always_comb begin
        live_rs = i_id_uses_rs && (i_id_rs != 5'd0);
        live_rt = i_id_uses_rt && (i_id_rt != 5'd0);
        ex_ok   = i_ex_reg_write  && (i_ex_write_register  != 5'd0);
        mem_ok  = i_mem_reg_write && (i_mem_write_register != 5'd0);
        wb_ok   = i_wb_reg_write  && (i_wb_write_register  != 5'd0);

        ex_hit_a  = live_rs && ex_ok  && (i_ex_write_register  == i_id_rs);
        mem_hit_a = live_rs && mem_ok && (i_mem_write_register == i_id_rs);
        wb_hit_a  = live_rs && wb_ok  && (i_wb_write_register  == i_id_rs);
        ex_hit_b  = live_rt && ex_ok  && (i_ex_write_register  == i_id_rt);
        mem_hit_b = live_rt && mem_ok && (i_mem_write_register == i_id_rt);
        wb_hit_b  = live_rt && wb_ok  && (i_wb_write_register  == i_id_rt);
    end

    // Stall length per source: the youngest matching producer decides.
    always_comb begin
        len_a = 2'd0;
        if (ex_hit_a)
            len_a = i_ex_mem_read ? 2'd2 : 2'd1;
        else if (mem_hit_a && i_mem_mem_read)
            len_a = 2'd1;

        len_b = 2'd0;
        if (ex_hit_b)
            len_b = i_ex_mem_read ? 2'd2 : 2'd1;
        else if (mem_hit_b && i_mem_mem_read)
            len_b = 2'd1;

        need_len = (len_a > len_b) ? len_a : len_b;
    end

    // An EX match hides older producers: their values would be stale.
    always_comb begin
        o_use_forwarded_a   = 1'b0;
        o_forwarded_value_a = 32'd0;
        if (!ex_hit_a && mem_hit_a) begin
            if (!i_mem_mem_read) begin
                o_use_forwarded_a   = 1'b1;
                o_forwarded_value_a = i_mem_alu_result;
            end
        end else if (!ex_hit_a && wb_hit_a) begin
            o_use_forwarded_a   = 1'b1;
            o_forwarded_value_a = i_wb_write_data;
        end

        o_use_forwarded_b   = 1'b0;
        o_forwarded_value_b = 32'd0;
        if (!ex_hit_b && mem_hit_b) begin
            if (!i_mem_mem_read) begin
                o_use_forwarded_b   = 1'b1;
                o_forwarded_value_b = i_mem_alu_result;
            end
        end else if (!ex_hit_b && wb_hit_b) begin
            o_use_forwarded_b   = 1'b1;
            o_forwarded_value_b = i_wb_write_data;
        end
    end

    always_comb begin
        o_stall    = (state == STALL_LAST) || (need_len != 2'd0);
        o_bubble   = o_stall;
        o_flush_if = i_id_take_branch && !o_stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            o_stall_count <= 16'd0;
            o_flush_count <= 16'd0;
        end else begin
            case (state)
                RUN:        state <= (need_len == 2'd2) ? STALL_LAST : RUN;
                STALL_LAST: state <= RUN;
                default:    state <= RUN;
            endcase
            if (o_stall && (o_stall_count != 16'hFFFF))
                o_stall_count <= o_stall_count + 16'd1;
            if (o_flush_if && (o_flush_count != 16'hFFFF))
                o_flush_count <= o_flush_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_hazard_forward_unit.sv
// Bench for id_hazard_forward_unit: directed vector table, random stimulus
// against a stall-budget reference model, and counter saturation.
module tb_id_hazard_forward_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  i_id_rs, i_id_rt;
    logic        i_id_uses_rs, i_id_uses_rt, i_id_take_branch;
    logic        i_ex_reg_write, i_ex_mem_read;
    logic [4:0]  i_ex_write_register;
    logic        i_mem_reg_write, i_mem_mem_read;
    logic [4:0]  i_mem_write_register;
    logic [31:0] i_mem_alu_result;
    logic        i_wb_reg_write;
    logic [4:0]  i_wb_write_register;
    logic [31:0] i_wb_write_data;
    logic [31:0] o_forwarded_value_a, o_forwarded_value_b;
    logic        o_use_forwarded_a, o_use_forwarded_b;
    logic        o_stall, o_bubble, o_flush_if;
    logic [15:0] o_stall_count, o_flush_count;

    id_hazard_forward_unit dut (
        .clk(clk), .reset(reset),
        .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
        .i_id_uses_rs(i_id_uses_rs), .i_id_uses_rt(i_id_uses_rt),
        .i_id_take_branch(i_id_take_branch),
        .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read),
        .i_ex_write_register(i_ex_write_register),
        .i_mem_reg_write(i_mem_reg_write), .i_mem_mem_read(i_mem_mem_read),
        .i_mem_write_register(i_mem_write_register),
        .i_mem_alu_result(i_mem_alu_result),
        .i_wb_reg_write(i_wb_reg_write),
        .i_wb_write_register(i_wb_write_register),
        .i_wb_write_data(i_wb_write_data),
        .o_forwarded_value_a(o_forwarded_value_a),
        .o_forwarded_value_b(o_forwarded_value_b),
        .o_use_forwarded_a(o_use_forwarded_a),
        .o_use_forwarded_b(o_use_forwarded_b),
        .o_stall(o_stall), .o_bubble(o_bubble), .o_flush_if(o_flush_if),
        .o_stall_count(o_stall_count), .o_flush_count(o_flush_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    typedef struct {
        logic rst; logic [4:0] rs, rt; logic urs, urt, br;
        logic exw, exm; logic [4:0] exd;
        logic mw, mm; logic [4:0] md; logic [31:0] malu;
        logic ww; logic [4:0] wd; logic [31:0] wdat;
        logic e_st, e_ua; logic [31:0] e_va; logic e_ub; logic [31:0] e_vb;
        logic e_fl; logic [15:0] e_sc, e_fc;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic [4:0] rs, rt, input logic urs, urt, br,
        input logic exw, exm, input logic [4:0] exd,
        input logic mw, mm, input logic [4:0] md, input logic [31:0] malu,
        input logic ww, input logic [4:0] wd, input logic [31:0] wdat,
        input logic st, ua, input logic [31:0] va, input logic ub, input logic [31:0] vb,
        input logic fl, input logic [15:0] sc, fc);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.br = br;
        v.exw = exw; v.exm = exm; v.exd = exd;
        v.mw = mw; v.mm = mm; v.md = md; v.malu = malu;
        v.ww = ww; v.wd = wd; v.wdat = wdat;
        v.e_st = st; v.e_ua = ua; v.e_va = va; v.e_ub = ub; v.e_vb = vb;
        v.e_fl = fl; v.e_sc = sc; v.e_fc = fc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; i_id_rs = v.rs; i_id_rt = v.rt;
        i_id_uses_rs = v.urs; i_id_uses_rt = v.urt; i_id_take_branch = v.br;
        i_ex_reg_write = v.exw; i_ex_mem_read = v.exm; i_ex_write_register = v.exd;
        i_mem_reg_write = v.mw; i_mem_mem_read = v.mm; i_mem_write_register = v.md;
        i_mem_alu_result = v.malu;
        i_wb_reg_write = v.ww; i_wb_write_register = v.wd; i_wb_write_data = v.wdat;
    endtask

    task automatic drive_idle(input logic rst);
        drive(mk(rst, 0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0,0,0));
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic st, ua, input logic [31:0] va,
                                 input logic ub, input logic [31:0] vb, input logic fl,
                                 input logic [15:0] sc, fc);
        chk({tag, ".stall"},  32'(o_stall), 32'(st));
        chk({tag, ".bubble"}, 32'(o_bubble), 32'(st));
        chk({tag, ".flush"},  32'(o_flush_if), 32'(fl));
        chk({tag, ".use_a"},  32'(o_use_forwarded_a), 32'(ua));
        chk({tag, ".val_a"},  o_forwarded_value_a, va);
        chk({tag, ".use_b"},  32'(o_use_forwarded_b), 32'(ub));
        chk({tag, ".val_b"},  o_forwarded_value_b, vb);
        chk({tag, ".scnt"},   32'(o_stall_count), 32'(sc));
        chk({tag, ".fcnt"},   32'(o_flush_count), 32'(fc));
    endtask

    // ---------------- reference model ----------------
    // The front end owes "pending" extra stall cycles after a load-use in EX.
    int pending = 0;
    int sc_m = 0;
    int fc_m = 0;

    function automatic void src_model(input logic use_src, input logic [4:0] src,
                                      output int len, output logic fw, output logic [31:0] val);
        logic        w[3];
        logic [4:0]  d[3];
        logic        found;
        w = '{i_ex_reg_write, i_mem_reg_write, i_wb_reg_write};
        d = '{i_ex_write_register, i_mem_write_register, i_wb_write_register};
        len = 0; fw = 1'b0; val = 32'd0; found = 1'b0;
        if (use_src && src != 5'd0) begin
            for (int s = 0; s < 3; s++) begin
                if (!found && w[s] && d[s] == src) begin
                    found = 1'b1;
                    if (s == 0) len = i_ex_mem_read ? 2 : 1;
                    else if (s == 1) begin
                        if (i_mem_mem_read) len = 1;
                        else begin fw = 1'b1; val = i_mem_alu_result; end
                    end else begin
                        fw = 1'b1; val = i_wb_write_data;
                    end
                end
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [99:0] exp_q[$];

    initial begin
        vec_t tbl[20];
        int la, lb, need;
        logic fa, fb, st, fl;
        logic [31:0] va, vb;
        logic [99:0] e;

        // rst rs rt urs urt br | exw exm exd | mw mm md alu | ww wd data || st ua va ub vb fl sc fc
        tbl[0]  = mk(0,5,6,1,1,0, 1,1,5, 0,0,0,0,       0,0,0,      1,0,0,0,0,0,0,0);
        tbl[1]  = mk(0,5,6,1,1,0, 0,0,0, 1,1,5,0,       0,0,0,      1,0,0,0,0,0,1,0);
        tbl[2]  = mk(0,5,6,1,1,0, 0,0,0, 0,0,0,0,       1,5,'h1234, 0,1,'h1234,0,0,0,2,0);
        tbl[3]  = mk(0,7,7,1,1,0, 1,0,7, 0,0,0,0,       0,0,0,      1,0,0,0,0,0,2,0);
        tbl[4]  = mk(0,7,7,1,1,0, 0,0,0, 1,0,7,'hCAFE,  0,0,0,      0,1,'hCAFE,1,'hCAFE,0,3,0);
        tbl[5]  = mk(0,3,0,1,0,0, 0,0,0, 1,0,3,'h11,    1,3,'h22,   0,1,'h11,0,0,0,3,0);
        tbl[6]  = mk(0,0,0,1,1,0, 1,1,0, 0,0,0,0,       1,0,'h99,   0,0,0,0,0,0,3,0);
        tbl[7]  = mk(0,0,0,0,0,1, 0,0,0, 0,0,0,0,       0,0,0,      0,0,0,0,0,1,3,0);
        tbl[8]  = mk(0,4,0,1,0,1, 1,1,4, 0,0,0,0,       0,0,0,      1,0,0,0,0,0,3,1);
        tbl[9]  = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,       0,0,0,      1,0,0,0,0,0,4,1);
        tbl[10] = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,       0,0,0,      0,0,0,0,0,0,5,1);
        tbl[11] = mk(0,9,0,1,0,0, 1,1,9, 0,0,0,0,       0,0,0,      1,0,0,0,0,0,5,1);
        tbl[12] = mk(1,0,0,0,0,0, 0,0,0, 0,0,0,0,       0,0,0,      1,0,0,0,0,0,6,1);
        tbl[13] = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,       0,0,0,      0,0,0,0,0,0,0,0);
        tbl[14] = mk(0,1,2,1,1,0, 1,1,2, 1,1,1,0,       0,0,0,      1,0,0,0,0,0,0,0);
        tbl[15] = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,       0,0,0,      1,0,0,0,0,0,1,0);
        tbl[16] = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,       0,0,0,      0,0,0,0,0,0,2,0);
        tbl[17] = mk(0,5,0,1,0,0, 0,1,5, 0,0,0,0,       0,0,0,      0,0,0,0,0,0,2,0);
        tbl[18] = mk(0,6,8,1,1,0, 0,0,0, 1,0,6,'hAA,    1,8,'hBB,   0,1,'hAA,1,'hBB,0,2,0);
        tbl[19] = mk(0,6,0,0,0,0, 1,1,6, 0,0,0,0,       0,0,0,      0,0,0,0,0,0,2,0);

        drive_idle(1'b1);
        repeat (2) next_edge();
        drive_idle(1'b0);
        @(negedge clk);
        check_outputs("reset", 0,0,0,0,0,0,0,0);
        next_edge();

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), tbl[i].e_st, tbl[i].e_ua, tbl[i].e_va,
                          tbl[i].e_ub, tbl[i].e_vb, tbl[i].e_fl, tbl[i].e_sc, tbl[i].e_fc);
            next_edge();
        end

        // Randomized traffic against the model, starting from a clean reset.
        drive_idle(1'b1);
        next_edge();
        pending = 0; sc_m = 0; fc_m = 0;
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            i_id_rs = 5'($urandom_range(0, 7)); i_id_rt = 5'($urandom_range(0, 7));
            i_id_uses_rs = 1'($urandom); i_id_uses_rt = 1'($urandom);
            i_id_take_branch = ($urandom_range(0, 3) == 0);
            i_ex_reg_write = 1'($urandom); i_ex_mem_read = 1'($urandom);
            i_ex_write_register = 5'($urandom_range(0, 7));
            i_mem_reg_write = 1'($urandom); i_mem_mem_read = 1'($urandom);
            i_mem_write_register = 5'($urandom_range(0, 7));
            i_mem_alu_result = $urandom;
            i_wb_reg_write = 1'($urandom);
            i_wb_write_register = 5'($urandom_range(0, 7));
            i_wb_write_data = $urandom;

            src_model(i_id_uses_rs, i_id_rs, la, fa, va);
            src_model(i_id_uses_rt, i_id_rt, lb, fb, vb);
            need = (la > lb) ? la : lb;
            st = (pending > 0) || (need > 0);
            fl = i_id_take_branch && !st;
            exp_q.push_back({st, fl, fa, va, fb, vb, 16'(sc_m), 16'(fc_m)});

            @(negedge clk);
            e = exp_q.pop_front();
            check_outputs("rand", e[99], e[97], e[96:65], e[64], e[63:32], e[98],
                          e[31:16], e[15:0]);

            if (reset) begin
                pending = 0; sc_m = 0; fc_m = 0;
            end else begin
                if (st && sc_m < 65535) sc_m++;
                if (fl && fc_m < 65535) fc_m++;
                if (pending > 0) pending--;
                else if (need == 2) pending = 1;
            end
            next_edge();
        end

        // Stall counter saturation under a long single-cycle hazard.
        drive_idle(1'b1);
        next_edge();
        drive(mk(0,7,0,1,0,0, 1,0,7, 0,0,0,0, 0,0,0, 0,0,0,0,0,0,0,0));
        repeat (65540) @(posedge clk);
        #1;
        @(negedge clk);
        chk("sat.stall", 32'(o_stall), 32'd1);
        chk("sat.scnt", 32'(o_stall_count), 32'hFFFF);
        chk("sat.fcnt", 32'(o_flush_count), 32'd0);
        next_edge();
        @(negedge clk);
        chk("sat.hold", 32'(o_stall_count), 32'hFFFF);
        drive_idle(1'b1);
        next_edge();
        drive_idle(1'b0);
        @(negedge clk);
        chk("sat.clear", 32'(o_stall_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
